// File: rtl/tank_bullet_if.sv
// tank_bullet_if: tank/keyboard inputs and bullet outputs of the projectile stage.
// slave = projectile stage, master = its driver.
interface tank_bullet_if;
    logic [31:0]       keycode;
    logic [9:0]        TankX;
    logic [9:0]        TankY;
    logic signed [7:0] sin;
    logic signed [7:0] cos;
    logic              Hit;
    logic [9:0]        BulletX;
    logic [9:0]        BulletY;
    logic [9:0]        BulletS;
    logic              BulletActive;
    logic              Fired;

    modport master (
        output keycode, TankX, TankY, sin, cos, Hit,
        input  BulletX, BulletY, BulletS, BulletActive, Fired
    );

    modport slave (
        input  keycode, TankX, TankY, sin, cos, Hit,
        output BulletX, BulletY, BulletS, BulletActive, Fired
    );
endinterface

// File: rtl/tank_bullet.sv
// tank_bullet: one-shot projectile with lifetime, hit retire and cooldown.
// Define TANK_BULLET_BOUNCE_EN to reflect off edges instead of retiring.
module tank_bullet #(
    parameter logic [7:0] FIRE_KEY        = 8'h2C,
    parameter int         SPEED           = 4,
    parameter int         LIFE_FRAMES     = 240,
    parameter int         COOLDOWN_FRAMES = 15,
    parameter int         X_MIN           = 0,
    parameter int         X_MAX           = 639,
    parameter int         Y_MIN           = 0,
    parameter int         Y_MAX           = 479,
    parameter int         BULLET_SIZE     = 2
) (
    input logic         frame_clk,
    input logic         Reset,
    tank_bullet_if.slave bus
);

    localparam int LW = $clog2(LIFE_FRAMES + 1);
    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [LW-1:0] LIFE_INIT = LW'(LIFE_FRAMES);
    localparam logic [CW-1:0] CD_INIT   = CW'(COOLDOWN_FRAMES);
    localparam logic signed [15:0] SPD  = 16'(SPEED);
    localparam logic signed [10:0] X_LO = 11'(X_MIN + BULLET_SIZE);
    localparam logic signed [10:0] X_HI = 11'(X_MAX - BULLET_SIZE);
    localparam logic signed [10:0] Y_LO = 11'(Y_MIN + BULLET_SIZE);
    localparam logic signed [10:0] Y_HI = 11'(Y_MAX - BULLET_SIZE);

    typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

    state_t            state, state_nx;
    logic [9:0]        bx, by;
    logic signed [7:0] vx, vy;
    logic [LW-1:0]     life;
    logic [CW-1:0]     cd;
    logic              fire_prev, fired;
    logic              fire_now, fire_edge;
    logic signed [15:0] px, py;
    logic signed [7:0]  vx_new, vy_new;
    logic signed [10:0] nx, ny;
    logic              x_out, y_out;

    always_comb begin
        fire_now = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.keycode[8*i +: 8] == FIRE_KEY) fire_now = 1'b1;
        end
    end

    assign fire_edge = fire_now & ~fire_prev;

    // Floor toward -inf: arithmetic shift of the signed product.
    assign px     = $signed({{8{bus.cos[7]}}, bus.cos}) * SPD;
    assign py     = $signed({{8{bus.sin[7]}}, bus.sin}) * SPD;
    assign vx_new = 8'(px >>> 6);
    assign vy_new = 8'(py >>> 6);

    assign nx    = $signed({1'b0, bx}) + $signed({{3{vx[7]}}, vx});
    assign ny    = $signed({1'b0, by}) + $signed({{3{vy[7]}}, vy});
    assign x_out = (nx < X_LO) || (nx > X_HI);
    assign y_out = (ny < Y_LO) || (ny > Y_HI);

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (fire_edge) state_nx = FLYING;
            end
            FLYING: begin
                if (bus.Hit)              state_nx = COOLDOWN;
                else if (life == LW'(1))  state_nx = COOLDOWN;
`ifndef TANK_BULLET_BOUNCE_EN
                else if (x_out || y_out)  state_nx = COOLDOWN;
`endif
            end
            COOLDOWN: begin
                if (cd <= CW'(1)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            bx        <= '0;
            by        <= '0;
            vx        <= '0;
            vy        <= '0;
            life      <= '0;
            cd        <= '0;
            fire_prev <= 1'b1;
            fired     <= 1'b0;
        end else begin
            fire_prev <= fire_now;
            fired     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fire_edge) begin
                        bx    <= bus.TankX;
                        by    <= bus.TankY;
                        vx    <= vx_new;
                        vy    <= vy_new;
                        life  <= LIFE_INIT;
                        fired <= 1'b1;
                    end
                end
                FLYING: begin
                    if (state_nx == COOLDOWN) begin
                        cd <= CD_INIT;
                    end else begin
                        life <= life - LW'(1);
`ifdef TANK_BULLET_BOUNCE_EN
                        if (x_out) vx <= -vx;
                        else       bx <= nx[9:0];
                        if (y_out) vy <= -vy;
                        else       by <= ny[9:0];
`else
                        bx <= nx[9:0];
                        by <= ny[9:0];
`endif
                    end
                end
                COOLDOWN: begin
                    if (cd != '0) cd <= cd - CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.BulletActive = (state == FLYING);
        bus.Fired        = fired;
        bus.BulletX      = bx;
        bus.BulletY      = by;
        bus.BulletS      = 10'(BULLET_SIZE);
    end

endmodule
